// File: rtl/channel_frame_tx_if.sv
// rtl/channel_frame_tx_if.sv - request/status/serial bundle for channel_frame_tx
//
// Signals:
//   send     frame request (host -> framer)
//   data0    channel byte 0 (host -> framer)
//   data1    channel byte 1 (host -> framer)
//   busy     frame in progress (framer -> host)
//   done     one-cycle frame-complete pulse (framer -> host)
//   uart_tx  serial line, idle high (framer -> line)
// Modports: master (request side), slave (framer side).
interface channel_frame_tx_if;
    logic       send;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       busy;
    logic       done;
    logic       uart_tx;

    modport master (
        output send,
        output data0,
        output data1,
        input  busy,
        input  done,
        input  uart_tx
    );

    modport slave (
        input  send,
        input  data0,
        input  data1,
        output busy,
        output done,
        output uart_tx
    );
endinterface

// File: rtl/channel_frame_tx.sv
// rtl/channel_frame_tx.sv - 4-byte status frame serializer onto an 8N1 UART line
//
// Frame: HEADER, d0, d1, chk; each byte sent 8N1, LSB first, bytes back to back.
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   HEADER        first byte of every frame
// Ports:
//   CLK           system clock, rising edge
//   RST           asynchronous active-high reset
//   bus (slave)   send/data0/data1 in; busy/done/uart_tx out (all outputs registered)
// Optional feature macro: CHANNEL_FRAME_CRC8_EN
//   defined     -> chk = CRC-8 (poly 0x07, init 0x00, MSB first) over d0 then d1
//   not defined -> chk = d0 ^ d1
module channel_frame_tx #(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                 CLK,
    input  logic                 RST,
    channel_frame_tx_if.slave    bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       d0_q,       d0_d;
    logic [7:0]       d1_q,       d1_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic [7:0]       chk;
    logic [7:0]       cur_byte;
    logic             bit_end;

`ifdef CHANNEL_FRAME_CRC8_EN
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] b);
        logic [7:0] c;
        c = crc_in ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign chk = crc8_byte(crc8_byte(8'h00, d0_q), d1_q);
`else
    assign chk = d0_q ^ d1_q;
`endif

    always_comb begin
        cur_byte = HEADER;
        case (byte_idx_q)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = d0_q;
            2'd2:    cur_byte = d1_q;
            default: cur_byte = chk;
        endcase
    end

    assign bit_end = (clk_cnt_q == CNT_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // tx_d always carries the level of the bit that begins at the next edge,
    // so the registered line changes exactly on bit boundaries.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.send) begin
                    // Bytes are captured once here; later input changes cannot
                    // disturb the frame or its check byte.
                    d0_d       = bus.data0;
                    d1_d       = bus.data1;
                    state_d    = START;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                    tx_d      = cur_byte[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = cur_byte[bit_cnt_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d    = IDLE;
                        byte_idx_d = '0;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no gap.
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.uart_tx = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_channel_frame_tx.sv
// tb/tb_channel_frame_tx.sv - directed self-checking bench for channel_frame_tx
module tb_channel_frame_tx;

    localparam int CPB   = 4;
    localparam int NBITS = 40;
    localparam int FRAME = NBITS * CPB;

`ifdef CHANNEL_FRAME_CRC8_EN
    localparam logic [7:0] CHK_12_34 = 8'hF1;
    localparam logic [7:0] CHK_0F_00 = 8'hC3;
`else
    localparam logic [7:0] CHK_12_34 = 8'h26;
    localparam logic [7:0] CHK_0F_00 = 8'h0F;
`endif
    localparam logic [7:0] CHK_00_00 = 8'h00;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    channel_frame_tx_if bus ();

    channel_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .HEADER       (8'hA5)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Call at the negedge right after the acceptance edge. Samples 160 cycles,
    // decodes the four bytes, then checks the done cycle.
    // act_kind: 0 none, 1 data0<=FF at act_at, 2 send pulse at act_at.
    task automatic capture_frame(input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] ec, input int act_at,
                                 input int act_kind, input string tag);
        logic       bits [FRAME];
        logic [7:0] exp_b [4];
        logic [7:0] got;
        logic       ctrl_ok, start_ok, stop_ok, stable_ok;
        int         base;
        exp_b[0] = 8'hA5; exp_b[1] = e0; exp_b[2] = e1; exp_b[3] = ec;
        ctrl_ok = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            bits[i] = bus.uart_tx;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) ctrl_ok = 1'b0;
            if (i == act_at && act_kind == 1) bus.data0 = 8'hFF;
            if (i == act_at && act_kind == 2) bus.send = 1'b1;
            if (i == act_at + 1 && act_kind == 2) bus.send = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ctrl_ok) begin
            errors++;
            $display("FAIL %s busy_done_in_frame: busy/done not 1/0 throughout", tag);
        end
        for (int b = 0; b < 4; b++) begin
            start_ok = 1'b1; stop_ok = 1'b1; stable_ok = 1'b1; got = 8'h00;
            base = b * 10 * CPB;
            for (int c = 0; c < CPB; c++) begin
                if (bits[base + c] !== 1'b0) start_ok = 1'b0;
                if (bits[base + 9 * CPB + c] !== 1'b1) stop_ok = 1'b0;
            end
            for (int j = 0; j < 8; j++) begin
                got[j] = bits[base + (1 + j) * CPB];
                for (int c = 1; c < CPB; c++)
                    if (bits[base + (1 + j) * CPB + c] !== got[j]) stable_ok = 1'b0;
            end
            checks++;
            if (got !== exp_b[b] || !stable_ok) begin
                errors++;
                $display("FAIL %s byte%0d: got %02h (stable=%0b) expected %02h", tag, b, got, stable_ok, exp_b[b]);
            end
            checks++;
            if (!start_ok || !stop_ok) begin
                errors++;
                $display("FAIL %s framing%0d: start_ok=%0b stop_ok=%0b expected 1 1", tag, b, start_ok, stop_ok);
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle: done=%0b busy=%0b tx=%0b expected 1 0 1", tag, bus.done, bus.busy, bus.uart_tx);
        end
    endtask

    // Accept a frame: send asserted for one edge, leaves bench at the negedge after it.
    task automatic start_frame(input logic [7:0] d0, input logic [7:0] d1, input logic hold);
        bus.data0 = d0;
        bus.data1 = d1;
        bus.send  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.send = 1'b0;
    endtask

    // Watch n cycles for an idle line with no done pulse.
    task automatic check_quiet(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s quiet: %0d bad cycles, expected 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.send = 1'b0; bus.data0 = 8'h00; bus.data1 = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%0b busy=%0b done=%0b expected 1 0 0", bus.uart_tx, bus.busy, bus.done);
        end
        rst = 1'b0;
        check_quiet(50, "reset_idle");
    endtask

    task automatic test_single_frame();
        start_frame(8'h12, 8'h34, 1'b0);
        checks++;
        if (bus.uart_tx !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start_bit: tx=%0b busy=%0b expected 0 1", bus.uart_tx, bus.busy);
        end
        capture_frame(8'h12, 8'h34, CHK_12_34, -10, 0, "single");
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%0b expected 0", bus.done);
        end
        check_quiet(20, "single_after");
    endtask

    task automatic test_back_to_back();
        start_frame(8'h00, 8'h00, 1'b1);
        for (int f = 0; f < 3; f++) begin
            capture_frame(8'h00, 8'h00, CHK_00_00, -10, 0, $sformatf("b2b%0d", f));
            if (f == 2) bus.send = 1'b0;
            @(negedge clk);
            // Next frame's start bit must follow the done cycle directly.
            if (f < 2) begin
                checks++;
                if (bus.uart_tx !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart%0d: tx=%0b busy=%0b expected 0 1", f, bus.uart_tx, bus.busy);
                end
            end
        end
        check_quiet(20, "b2b_after");
    endtask

    task automatic test_input_change();
        start_frame(8'h0F, 8'h00, 1'b0);
        capture_frame(8'h0F, 8'h00, CHK_0F_00, 20, 1, "latch");
        check_quiet(20, "latch_after");
    endtask

    task automatic test_send_while_busy();
        start_frame(8'h12, 8'h34, 1'b0);
        capture_frame(8'h12, 8'h34, CHK_12_34, 30, 2, "ignore");
        check_quiet(200, "ignore_after");
    endtask

    task automatic test_mid_reset();
        start_frame(8'h12, 8'h34, 1'b0);
        repeat (70) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: busy=%0b expected 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx=%0b busy=%0b done=%0b expected 1 0 0", bus.uart_tx, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_quiet(200, "post_reset");
        start_frame(8'h12, 8'h34, 1'b0);
        capture_frame(8'h12, 8'h34, CHK_12_34, -10, 0, "after_reset");
        check_quiet(10, "after_reset_tail");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_input_change();
        test_send_while_busy();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
